// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Initiator side of the data-memory load/store path. Takes byte, halfword and
// word load/store requests from the core over a valid/ready handshake, drives
// a word-addressed 32-bit data memory, performs read-modify-write for
// sub-word stores, extracts and extends sub-word load data, and rejects
// misaligned, illegal-size or out-of-range accesses with an error response.
//
// Parameters:
//   ADDR_W        word-index width; the memory holds 2**ADDR_W 32-bit words.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   req_valid     core request present
//   req_ready     unit can accept a request (high only in IDLE)
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned  load zero-extends when 1, sign-extends when 0
//   req_addr      byte address
//   req_wdata     store data, right-aligned
//   resp_valid    one-cycle completion pulse (registered)
//   resp_err      qualifies resp_valid; the access was rejected
//   resp_rdata    load result; 0 for stores and errors
//   mem_read      memory read enable
//   mem_write     memory write enable
//   mem_addr      word index; bits above ADDR_W-1 are always 0
//   mem_wdata     memory write data
//   mem_rdata     memory read data, combinational in the mem_read cycle
//
// Optional feature (macro MEM_ACCESS_PERF_CNT_EN):
//   ld_count      successful load responses, saturating at 16'hFFFF
//   st_count      successful store responses, saturating at 16'hFFFF
//   err_count     error responses, saturating at 16'hFFFF
//   Without the macro these ports and counters are absent.
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int ADDR_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef MEM_ACCESS_PERF_CNT_EN
    ,
    output logic [15:0] ld_count,
    output logic [15:0] st_count,
    output logic [15:0] err_count
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD       = 3'd1;
    localparam logic [2:0] S_RMW_RD   = 3'd2;
    localparam logic [2:0] S_WR       = 3'd3;
    localparam logic [2:0] S_RESP     = 3'd4;
    localparam logic [2:0] S_RESP_ERR = 3'd5;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // -------------------------------------------------------------------------
    // State and latched request
    // -------------------------------------------------------------------------
    logic [2:0]        state_q,      state_d;
    logic              we_q,         we_d;
    logic [1:0]        size_q,       size_d;
    logic              uns_q,        uns_d;
    logic [1:0]        lane_q,       lane_d;
    logic [ADDR_W-1:0] widx_q,       widx_d;
    // Holds the raw store data after accept, then the merged word after the
    // read phase of a read-modify-write.
    logic [31:0]       wdata_q,      wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q,   resp_err_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------

    // Rejects illegal sizes, misalignment, and any address bit beyond the
    // memory's byte range.
    function automatic logic access_error(input logic [1:0]  size,
                                          input logic [31:0] addr);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = addr[0];
            SZ_WORD: err = |addr[1:0];
            default: err = 1'b1;
        endcase
        if ((addr >> (ADDR_W + 2)) != 32'd0) begin
            err = 1'b1;
        end
        return err;
    endfunction

    // Selects the addressed little-endian lane and extends it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic [31:0] bsh;
        logic [31:0] hsh;
        logic [31:0] res;
        bsh = word >> {lane, 3'b000};
        hsh = word >> {lane[1], 4'b0000};
        case (size)
            SZ_BYTE: res = uns ? {24'd0, bsh[7:0]}
                               : {{24{bsh[7]}}, bsh[7:0]};
            SZ_HALF: res = uns ? {16'd0, hsh[15:0]}
                               : {{16{hsh[15]}}, hsh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replaces the addressed byte or halfword lane of the old word with the
    // low bits of the store data; other lanes are preserved.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size);
        logic [31:0] mask;
        logic [31:0] ins;
        if (size == SZ_BYTE) begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            ins  = {24'd0, data[7:0]} << {lane, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {lane[1], 4'b0000};
            ins  = {16'd0, data[15:0]} << {lane[1], 4'b0000};
        end
        return (old & ~mask) | (ins & mask);
    endfunction

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        widx_d       = widx_q;
        wdata_d      = wdata_q;
        resp_rdata_d = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    lane_d  = req_addr[1:0];
                    widx_d  = req_addr[ADDR_W+1:2];
                    wdata_d = req_wdata;
                    if (access_error(req_size, req_addr)) begin
                        state_d = S_RESP_ERR;
                    end else if (!req_we) begin
                        state_d = S_RD;
                    end else if (req_size == SZ_WORD) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_RD: begin
                resp_rdata_d = load_extract(mem_rdata, lane_q, size_q, uns_q);
                state_d      = S_RESP;
            end
            S_RMW_RD: begin
                wdata_d = store_merge(mem_rdata, wdata_q, lane_q, size_q);
                state_d = S_WR;
            end
            S_WR: begin
                state_d = S_RESP;
            end
            S_RESP, S_RESP_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Response registers are loaded on the edge entering a response
        // state, so they are high exactly for that one cycle.
        resp_valid_d = (state_d == S_RESP) || (state_d == S_RESP_ERR);
        resp_err_d   = (state_d == S_RESP_ERR);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            widx_q       <= '0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            widx_q       <= widx_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // Memory strobes decode directly from the state register so that an
    // asynchronous reset removes mem_write before the next edge.
    assign req_ready  = (state_q == S_IDLE);
    assign mem_read   = (state_q == S_RD) || (state_q == S_RMW_RD);
    assign mem_write  = (state_q == S_WR);
    assign mem_addr   = (mem_read || mem_write) ? {{(32-ADDR_W){1'b0}}, widx_q}
                                                : 32'd0;
    assign mem_wdata  = mem_write ? wdata_q : 32'd0;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

`ifdef MEM_ACCESS_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
    logic [15:0] ld_cnt_q,  ld_cnt_d;
    logic [15:0] st_cnt_q,  st_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Each counter steps on the edge that ends its response cycle.
    always_comb begin
        ld_cnt_d  = ld_cnt_q;
        st_cnt_d  = st_cnt_q;
        err_cnt_d = err_cnt_q;
        if (state_q == S_RESP) begin
            if (we_q) begin
                st_cnt_d = sat_inc(st_cnt_q);
            end else begin
                ld_cnt_d = sat_inc(ld_cnt_q);
            end
        end else if (state_q == S_RESP_ERR) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_cnt_q  <= 16'd0;
            st_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
        end else begin
            ld_cnt_q  <= ld_cnt_d;
            st_cnt_q  <= st_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ld_count  = ld_cnt_q;
    assign st_count  = st_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory load/store interface.
- Accepts byte, halfword and word load/store requests from the core through a valid/ready handshake.
- Drives the word-addressed data memory (read/write enables, word index, write data).
- Performs read-modify-write for sub-word stores, extracts and extends sub-word load data, and flags misaligned or out-of-range accesses.

Parameters:
- ADDR_W, 6, word-index width; memory holds 2**ADDR_W 32-bit words.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  core request present.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal and treated as error.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  qualifies resp_valid; access was rejected.
- resp_rdata  output  32  load result; 0 for stores and errors.
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable.
- mem_addr  output  32  word index; bits above ADDR_W-1 are always 0.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data; combinational, valid in the same cycle as mem_read.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0 except req_ready=1; internal latches cleared.
- A reset asserted during any state returns the unit to IDLE immediately. mem_write drops asynchronously, so no write commits, and no response is issued.
- Handshake: a request is accepted when req_valid & req_ready at a rising edge. All req_* fields are latched at that edge. Inputs are ignored in other states.
- Error check at accept:
  - halfword with addr[0]=1 → error;
  - word with addr[1:0]≠0 → error;
  - size=11 → error;
  - req_addr[31:ADDR_W+2]≠0 → error.
- States:
  - IDLE: req_ready=1.
    - On accept with error → RESP_ERR.
    - Load → RD.
    - Word store → WR.
    - Byte/halfword store → RMW_RD.
  - RD: mem_read=1, mem_addr=latched addr[ADDR_W+1:2]. Capture mem_rdata → RESP.
  - RMW_RD: mem_read=1. Capture mem_rdata and merge the new byte/halfword into lanes selected by addr[1:0] (little-endian) → WR.
  - WR: mem_write=1, mem_read=0, mem_wdata = merged word (or req_wdata for a word store) → RESP.
  - RESP: resp_valid=1, resp_err=0, resp_rdata = extracted load data (0 for stores) → IDLE.
  - RESP_ERR: resp_valid=1, resp_err=1, resp_rdata=0; no memory access occurred → IDLE.
- mem_read and mem_write are never high in the same cycle. Both are 0 in IDLE, RESP and RESP_ERR.
- Load extraction:
  - byte lane = addr[1:0]; halfword lane = addr[1];
  - extend to 32 bits per req_unsigned.
- Latency from the accept edge to the resp_valid cycle:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- Throughput: a new request can be accepted in the cycle after RESP (back in IDLE); no overlap.
- resp_* outputs are registered and hold 0 outside the response cycle.

Optional Feature:
- Macro: MEM_ACCESS_PERF_CNT_EN.
- Defined:
  - adds outputs ld_count[15:0] and st_count[15:0];
  - each increments on a successful load/store response, saturating at 0xFFFF, and resets to 0 on rst_n;
  - also adds err_count[15:0], which counts RESP_ERR responses with the same saturation and reset rules.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Preload word 1 = 0x8000_12F0; load word, addr 0x4 → after 2 cycles resp_valid=1, resp_rdata=0x8000_12F0, resp_err=0.
- Same memory; load byte signed, addr 0x4 → 0xFFFF_FFF0. Load byte unsigned, addr 0x7 → 0x0000_0080. Load half signed, addr 0x6 → 0xFFFF_8000.
- Word 2 = 0x1122_3344; store byte 0xAB to addr 0xA:
  - mem_read high at accept+1; mem_write high at accept+2 with mem_wdata=0x11AB_3344;
  - resp_valid at accept+3.
- Word store to addr 0x6 → resp_err=1 one cycle after accept; mem_read and mem_write never asserted. Load word at addr 0x100 (ADDR_W=6) → error.
- Assert rst_n=0 during WR of a word store → mem_write drops immediately, memory unchanged, no resp_valid; after release req_ready=1.
- Hold req_valid high for 3 back-to-back loads → each accepted only in IDLE; responses spaced 3 cycles apart. With MEM_ACCESS_PERF_CNT_EN defined, ld_count=3.
